// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Framing definitions shared by the serial transmit framer and the serial
// receive path. Both ends import this package so the start/stop polarity, the
// frame length and the state names cannot drift apart.
//
// Contents:
//   tx_state_e   : framer state encoding (IDLE, START, DATA, STOP)
//   FRAME_BITS   : bits per frame on the line (start + 8 data + stop)
//   PAYLOAD_BITS : data bits per frame
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (also the idle level)
//   CNT_W        : width of the bit timer and bit index counters
//   tx_dbg_t     : debug snapshot of the framer (state and both counters)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int   FRAME_BITS   = 10;
  localparam int   PAYLOAD_BITS = 8;
  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;

  // Wide enough for a bit period of up to 15 clocks and a bit index of 8.
  localparam int   CNT_W        = 4;

  typedef struct packed {
    tx_state_e              state;
    logic [CNT_W-1:0]       bit_idx;
    logic [CNT_W-1:0]       bit_tmr;
  } tx_dbg_t;

endpackage : uart_pkg

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
//
// Run-time programmable up-counter. Counts 1..rollover_val while enabled, then
// wraps back to 1. A synchronous clear returns the count to 0 and has priority
// over counting.
//
// Ports:
//   clk           : system clock, rising edge
//   n_rst         : asynchronous active-low reset (count -> 0)
//   clear         : synchronous clear to 0
//   count_enable  : advance the count on this edge
//   rollover_val  : terminal count
//   count_out     : current count
//   rollover_flag : high in the cycle whose closing edge loads rollover_val,
//                   i.e. the count reaches its terminal value on that edge
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = ONE;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Look-ahead flag: the owner can act on the same edge that completes the
  // count, so a period of N clocks really is N clocks long.
  assign rollover_flag = !clear && count_enable && (count_d == rollover_val);
  assign count_out     = count_q;

endmodule : flex_counter

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Serial transmitter: accepts one byte through a valid/ready handshake and
// sends it as a 10-bit frame, LSB first: start bit (0), 8 data bits, stop
// bit (1). Each bit lasts CLKS_PER_BIT clocks, so a frame is exactly
// 10*CLKS_PER_BIT clocks. The line idles high.
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, legal range 2..15
//   DATA_BITS    : payload bits per frame, fixed at 8
//
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset; drives the line high at once
//   tx_data    : byte to send, sampled only on the handshake edge
//   tx_valid   : source offers a byte
//   tx_ready   : framer can take a byte this cycle (IDLE only)
//   tx_busy    : a frame is on the line (START, DATA or STOP)
//   tx_done    : one-cycle pulse in the first IDLE cycle after a stop bit
//   serial_out : registered serial line
//   dbg        : state and counter snapshot for observation
//
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready
// are both 1. tx_ready depends only on state, never on tx_valid. tx_valid
// while busy is dropped (not queued); the source must hold it until it sees
// tx_ready. The first IDLE cycle after a frame already accepts a byte, giving
// a minimum frame-to-frame period of 10*CLKS_PER_BIT+1 clocks.
// -----------------------------------------------------------------------------
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out,
  output tx_dbg_t              dbg
);

  localparam logic [CNT_W-1:0] TMR_ROLL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] IDX_ROLL = CNT_W'(DATA_BITS);

  tx_state_e              state_q,  state_d;
  logic [DATA_BITS-1:0]   shift_q,  shift_d;
  logic                   serial_q, serial_d;
  logic                   done_q,   done_d;

  logic [CNT_W-1:0]       tmr_cnt;
  logic                   tmr_roll;
  logic [CNT_W-1:0]       idx_cnt;
  logic                   idx_roll;
  logic                   idx_en;
  logic                   idx_clr;

  // ---------------------------------------------------------------------------
  // Bit-period timer. Held at 0 in IDLE, so every frame starts with a full
  // bit period. tmr_roll is high in the last clock of each bit.
  // ---------------------------------------------------------------------------
  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!tx_busy),
    .count_enable  (tx_busy),
    .rollover_val  (TMR_ROLL),
    .count_out     (tmr_cnt),
    .rollover_flag (tmr_roll)
  );

  // ---------------------------------------------------------------------------
  // Bit index counter. Steps once per completed data bit; its flag marks the
  // end of the last data bit. Cleared outside DATA so each frame starts at 0.
  // ---------------------------------------------------------------------------
  assign idx_en  = tmr_roll && (state_q == DATA);
  assign idx_clr = (state_q != DATA);

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_index (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (idx_clr),
    .count_enable  (idx_en),
    .rollover_val  (IDX_ROLL),
    .count_out     (idx_cnt),
    .rollover_flag (idx_roll)
  );

  // ---------------------------------------------------------------------------
  // Framing FSM and shift register.
  // The line level for the next bit is loaded into serial_q on the same edge
  // that ends the current bit; the shift register always holds the next data
  // bit in position 0, so each bit boundary both samples bit 0 and shifts.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d = STOP_BIT;
        if (tx_valid) begin
          state_d  = START;
          shift_d  = tx_data;
          serial_d = START_BIT;
        end
      end

      START: begin
        if (tmr_roll) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end

      DATA: begin
        if (tmr_roll) begin
          shift_d = shift_q >> 1;
          if (idx_roll) begin
            state_d  = STOP;
            serial_d = STOP_BIT;
          end else begin
            serial_d = shift_q[0];
          end
        end
      end

      STOP: begin
        if (tmr_roll) begin
          state_d  = IDLE;
          serial_d = STOP_BIT;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      serial_q <= STOP_BIT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_ready   = (state_q == IDLE);
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done_q;
  assign serial_out = serial_q;

  assign dbg.state   = state_q;
  assign dbg.bit_idx = idx_cnt;
  assign dbg.bit_tmr = tmr_cnt;

endmodule : uart_tx_framer

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Three framers with CLKS_PER_BIT = 10, 2 and 15. Drivers push the expected
// byte and handshake cycle into a per-instance queue; one monitor per
// instance watches the line, pops the queue on every start bit and compares
// the waveform, the recovered byte and the end-of-frame outputs against a
// frame built directly from the line rules (0, data LSB first, 1).
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  typedef struct packed {
    logic        abort;
    logic [31:0] t0;
    logic [7:0]  data;
  } exp_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic n_rst;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic [2:0]       valid;
  logic [7:0]       data [3];
  logic [2:0]       ready;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0]       ser;
  uart_pkg::tx_dbg_t dbg0, dbg1, dbg2;

  uart_tx_framer #(.CLKS_PER_BIT(10)) u_dut10 (
    .clk(clk), .n_rst(n_rst), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]),
    .serial_out(ser[0]), .dbg(dbg0)
  );

  uart_tx_framer #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]),
    .serial_out(ser[1]), .dbg(dbg1)
  );

  uart_tx_framer #(.CLKS_PER_BIT(15)) u_dut15 (
    .clk(clk), .n_rst(n_rst), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]),
    .serial_out(ser[2]), .dbg(dbg2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clks_of(input int k);
    case (k)
      0:       return 10;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  // Reference line level for bit position j of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return d[j-1];
  endfunction

  task automatic q_push(input int k, input exp_t e);
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (k)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: a behavioural line receiver per instance
  // ---------------------------------------------------------------------------
  task automatic monitor(input int k);
    int         c;
    exp_t       e;
    bit         ok;
    bit         prev;
    bit         aborted;
    int         bad_smp;
    logic [7:0] got;
    c    = clks_of(k);
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev = 1'b1;
      end else if (prev && !ser[k]) begin
        q_pop(k, e, ok);
        check($sformatf("frame_expected[%0d]", k), 32'(ok), 32'd1);
        if (ok) begin
          check($sformatf("start_cycle[%0d]", k), cyc, e.t0);
          aborted = 1'b0;
          bad_smp = 0;
          got     = '0;
          for (int i = 0; i < 10 * c; i++) begin
            if (i > 0) @(negedge clk);
            if (!n_rst) begin
              aborted = 1'b1;
              break;
            end
            if (ser[k] !== exp_bit(e.data, i / c) || busy[k] !== 1'b1 ||
                ready[k] !== 1'b0 || done[k] !== 1'b0) bad_smp++;
            if ((i % c) == (c / 2) && (i / c) >= 1 && (i / c) <= 8) got[i / c - 1] = ser[k];
          end
          check($sformatf("aborted[%0d]", k), 32'(aborted), 32'(e.abort));
          if (!aborted) begin
            check($sformatf("frame_shape[%0d] byte %0h", k, e.data), bad_smp, 0);
            check($sformatf("rx_byte[%0d]", k), 32'(got), 32'(e.data));
            @(negedge clk);
            check($sformatf("frame_end[%0d] ser,busy,ready,done", k),
                  {28'd0, ser[k], busy[k], ready[k], done[k]}, 32'b1011);
          end
        end
        prev = n_rst ? ser[k] : 1'b1;
      end else begin
        if (done[k] || (ser[k] && busy[k]))
          check($sformatf("idle_busy_done[%0d]", k), {30'd0, busy[k], done[k]}, 32'd0);
        prev = ser[k];
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send(input int k, input logic [7:0] d, input bit abort_exp,
                      input bit hold, output int t0);
    int guard;
    guard    = 0;
    valid[k] = 1'b1;
    data[k]  = d;
    while (!ready[k] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready[k]) begin
      check($sformatf("handshake_timeout[%0d]", k), 32'(ready[k]), 32'd1);
      valid[k] = 1'b0;
      t0 = cyc;
      return;
    end
    t0 = cyc + 1;
    q_push(k, '{abort: abort_exp, t0: 32'(t0), data: d});
    @(negedge clk);
    if (!hold) begin
      valid[k] = 1'b0;
      data[k]  = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int k);
    int guard;
    guard = 0;
    while ((busy[k] || !ready[k]) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("wait_idle[%0d]", k), 32'(busy[k]), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int t1;
    int k;
    int gap;
    valid = '0;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ser_busy_ready_done", {20'd0, ser, busy, ready, done}, {20'd0, 3'b111, 3'b000, 3'b111, 3'b000});
    check("rst_dbg", {dbg0, dbg1, dbg2}, 32'd0);
    #1 n_rst = 1'b1;

    // Quiet line after reset
    repeat (50) @(negedge clk);
    check("idle_line_50", {23'd0, ser, busy, ready}, {23'd0, 3'b111, 3'b000, 3'b111});

    // Single byte
    send(0, 8'hA5, 1'b0, 1'b0, t0);
    wait_idle(0);

    // Back-to-back with tx_valid held
    send(0, 8'h00, 1'b0, 1'b1, t0);
    send(0, 8'hFF, 1'b0, 1'b0, t1);
    check("b2b_period", t1 - t0, 101);
    wait_idle(0);

    // tx_valid while busy is dropped
    send(0, 8'hA5, 1'b0, 1'b0, t0);
    while (cyc < t0 + 39) @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'h3C;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (150) @(negedge clk);
    check("ignored_no_frame", {31'd0, busy[0]}, 32'd0);

    // Reset during data bit 3
    send(0, 8'hC3, 1'b1, 1'b0, t0);
    while (cyc < t0 + 43) @(negedge clk);
    #1 n_rst = 1'b0;
    #1 check("midrst_ser_busy_ready_done", {28'd0, ser[0], busy[0], ready[0], done[0]}, 32'b1010);
    repeat (3) @(negedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b0, t0);
    wait_idle(0);

    // Bit period sweep
    send(1, 8'h5A, 1'b0, 1'b0, t0);
    wait_idle(1);
    send(2, 8'h5A, 1'b0, 1'b0, t0);
    wait_idle(2);

    // Random traffic across all three instances
    for (int n = 0; n < 14; n++) begin
      k   = $urandom_range(0, 2);
      gap = $urandom_range(0, 30);
      send(k, 8'($urandom), 1'b0, 1'b0, t0);
      repeat (gap) @(negedge clk);
    end

    repeat (400) @(negedge clk);
    check("leftover_q0", exp_q0.size(), 0);
    check("leftover_q1", exp_q1.size(), 0);
    check("leftover_q2", exp_q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule : tb_uart_tx_framer

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial transmitter that is the mirror of the existing serial-in receive path. It accepts a parallel byte through a valid/ready handshake and emits a 10-bit frame on serial_out, LSB first: start bit 0, 8 data bits, stop bit 1. Each bit is held for exactly CLKS_PER_BIT clocks, matching the receiver's 10-clock bit period. It sits between the transmit data source (FIFO or controller) and the serial line pin.

Parameters:
CLKS_PER_BIT, 10, clocks per serial bit; legal range 2..15.
DATA_BITS, 8, payload bits per frame; fixed at 8 for this revision.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
tx_data  input  8  byte to transmit; sampled only on handshake cycle.
tx_valid  input  1  source has a byte for transmission.
tx_ready  output  1  block can accept a byte this cycle (IDLE only).
tx_busy  output  1  frame in progress (START, DATA or STOP).
tx_done  output  1  one-cycle pulse on the first IDLE cycle after a stop bit completes.
serial_out  output  1  serial line; idle high.

Behaviour:
- Reset (async, n_rst=0) values: state IDLE, serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, shift register 0, counters 0.
- States: IDLE, START, DATA, STOP. serial_out is registered; no combinational path from any input to serial_out.
- Handshake: transfer occurs on a rising edge with tx_valid=1 and tx_ready=1. tx_data is latched into an 8-bit shift register.
- tx_valid while busy is ignored and is not queued. tx_data changes outside the handshake cycle have no effect.
- Timing, with handshake at edge T0:
  - serial_out=0 for edges T0..T0+CLKS_PER_BIT (START).
  - Data bit i is driven from T0+(i+1)*CLKS_PER_BIT for CLKS_PER_BIT clocks, LSB first (DATA).
  - serial_out=1 from T0+9*CLKS_PER_BIT for CLKS_PER_BIT clocks (STOP).
  - At edge T0+10*CLKS_PER_BIT: state=IDLE, tx_done=1 for exactly one cycle, tx_ready=1.
- Frame length is exactly 10*CLKS_PER_BIT clocks (100 at default).
- Back-to-back: a new handshake is accepted in that first IDLE cycle, so the minimum frame-to-frame period is 10*CLKS_PER_BIT+1 clocks. serial_out stays 1 during the gap cycle.
- Bit timer: counts 1..CLKS_PER_BIT while busy and is cleared in IDLE. Its rollover advances the state or the bit index and shifts the register right by 1.
- Bit index counter: counts 0..7 in DATA; the rollover at 8 bits moves DATA to STOP.
- tx_busy = (state != IDLE); tx_ready = (state == IDLE).
- Reset mid-frame: the line returns to 1 immediately (asynchronous). The partial frame is abandoned, with no tx_done.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP), constants FRAME_BITS=10, START_BIT=1'b0, STOP_BIT=1'b1.
- The receiver uses the same package so both ends agree on framing.
- Sub-modules: two instances of the existing flex_counter.
  - Bit-period timer: rollover_val=CLKS_PER_BIT, clear=!tx_busy.
  - Bit index counter: rollover_val=8, enabled by the timer rollover in DATA.
- FSM and shift register are local to uart_tx_framer.

Test Plan:
- Reset check: hold n_rst=0 -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0. Release reset with no tx_valid for 50 clocks -> line stays 1.
- Single byte 8'hA5 at default parameter -> serial_out samples at the bit centres are 0,1,0,1,0,0,1,0,1,1. tx_busy is high for exactly 100 clocks. tx_done pulses once, 100 clocks after the handshake.
- Back-to-back 8'h00 then 8'hFF, with tx_valid held high -> second start bit begins exactly 101 clocks after the first handshake. Second frame is 0,1×8,1.
- Ignore while busy: pulse tx_valid with 8'h3C at clock 40 of an 8'hA5 frame -> 8'hA5 is transmitted unchanged, no second frame follows, tx_ready stays 0 throughout.
- Mid-frame reset: assert n_rst=0 during data bit 3 -> serial_out=1 in the same cycle, no tx_done. After release, the next byte 8'h81 is sent correctly.
- Parameter sweep with CLKS_PER_BIT=2 and 15, byte 8'h5A -> frame length is 20 and 150 clocks respectively, bit values are correct, and the receiver loopback recovers 8'h5A.
